calc_seq_ctrl: RTL and testbench
================================

// Module: calc_seq_ctrl
// PURPOSE
//  Operand-entry and operation sequencer for the calculator. It consumes one-cycle key
//  events from the keypad decoder stage and builds operands A and B as unsigned binary.
//  It launches the ALU with a start/done handshake, chains operators and drives the
//  display value. Sits between the keypad decoder and the arithmetic unit.
// PARAMETERS
//  WIDTH       16  operand/result width (bits)
//  MAX_DIGITS  4   max decimal digits per operand; 10**MAX_DIGITS-1 must fit in WIDTH
// PORTS
//  clk         in   1      system clock, all logic on rising edge
//  rst         in   1      asynchronous, active-low reset
//  key_valid   in   1      one-cycle key event strobe
//  key_code    in   4      0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear
//  alu_start   out  1      one-cycle launch pulse to ALU
//  alu_op      out  2      00 add, 01 sub, 10 mul, 11 div (matches decoder sel encoding)
//  alu_a       out  WIDTH  operand A, stable from alu_start until alu_done
//  alu_b       out  WIDTH  operand B, stable from alu_start until alu_done
//  alu_done    in   1      one-cycle completion strobe
//  alu_result  in   WIDTH  result, valid with alu_done
//  alu_err     in   1      overflow/underflow/div-by-zero, valid with alu_done
//  disp_val    out  WIDTH  value to display
//  disp_err    out  1      error indicator
//  busy        out  1      high in EXEC/FLUSH; non-clear keys are dropped
// BEHAVIOUR
//  Reset: state ENTER_A; A=B=0; digit counters 0; op=00; alu_start=0; disp_val=0;
//   disp_err=0; busy=0. All outputs registered; key at cycle n takes effect at n+1.
//  Digit: value = value*10 + d, count+1; ignored when count==MAX_DIGITS (no wrap).
//  ENTER_A: digit->accumulate A, disp_val=A. op->latch op, B=0, cntB=0, ->ENTER_B.
//   equals ignored.
//  ENTER_B: digit->accumulate B, disp_val=B. op with cntB==0 replaces latched op.
//   op with cntB>0 sets pend_op=new op, pend=1, ->EXEC. equals with cntB==0 ignored;
//   with cntB>0 sets pend=0, ->EXEC.
//  EXEC: alu_start high exactly the first cycle in EXEC; alu_a/alu_b/alu_op held.
//   On alu_done with alu_err=0: A=alu_result, disp_val=result. If pend=1: op=pend_op,
//   B=0, cntB=0, ->ENTER_B (display keeps result). Else ->RESULT.
//   On alu_done with alu_err=1: ->ERROR, disp_err=1, disp_val=0.
//  RESULT: digit->A=d, cntA=1, ->ENTER_A. op->latch op, chain on A, ->ENTER_B.
//   equals ignored.
//  ERROR: every key except clear ignored.
//  Clear (any state): A=B=0, counters 0, disp_val=0, disp_err=0, op=00.
//   In EXEC without alu_done in the same cycle: ->FLUSH (busy stays 1); wait for
//   alu_done, discard it, ->ENTER_A. Otherwise ->ENTER_A directly.
//  FLUSH: non-clear keys dropped; clear has no further effect.
//  Same-cycle key_valid and alu_done in EXEC: clear wins and the result is discarded;
//   any other key is dropped and done is processed.
//  Keys arriving while busy=1 are lost; no queueing.
//  Reset asserted mid-EXEC: immediate return to reset state; a later alu_done outside
//   EXEC/FLUSH is ignored.
// TESTING
//  Keys 1,2,add,3,equals; ALU done result 15 -> one alu_start, a=12 b=3 op=00; disp_val 15.
//  Digits 9,9,9,9,9 -> A=9999, fifth digit ignored; disp_val 9999.
//  Keys 5,mul,sub,2,equals -> op replaced; alu_op=01, a=5, b=2.
//  Keys 6,add,4,mul (done=10),3,equals (done=30) -> two starts; second a=10 b=3 op=10;
//   disp_val 30.
//  Keys 8,div,0,equals; alu_err=1 -> disp_err=1; keys 7,add ignored; clear -> disp_err=0,
//   disp_val=0.
//  Clear during EXEC, alu_done 3 cycles later -> FLUSH; done discarded; ENTER_A; A=0.

Source files
------------

// File: rtl/calc_seq_ctrl.sv
// Calculator operand-entry and operation sequencer.
// Builds decimal operands from key events, launches the ALU and chains operators.
module calc_seq_ctrl #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             alu_start,
  output logic [1:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_err,
  output logic [WIDTH-1:0] disp_val,
  output logic             disp_err,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(MAX_DIGITS + 1);

  typedef enum logic [2:0] {
    S_ENTER_A, S_ENTER_B, S_EXEC, S_RESULT, S_ERROR, S_FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, disp_q, disp_d;
  logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic [1:0]       op_q, op_d, pend_op_q, pend_op_d;
  logic             pend_q, pend_d, err_q, err_d, start_q, start_d, busy_q, busy_d;

  logic       is_digit, is_op, is_eq, is_clr;
  logic [1:0] key_op;

  assign is_digit = (key_code < 4'd10);
  assign is_op    = (key_code >= 4'd10) && (key_code <= 4'd13);
  assign is_eq    = (key_code == 4'd14);
  assign is_clr   = (key_code == 4'd15);
  assign key_op   = 2'(key_code - 4'd10);

  function automatic logic [WIDTH-1:0] acc(input logic [WIDTH-1:0] v, input logic [3:0] d);
    return WIDTH'(v * WIDTH'(10)) + WIDTH'(d);
  endfunction

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_a_d   = cnt_a_q;
    cnt_b_d   = cnt_b_q;
    op_d      = op_q;
    pend_op_d = pend_op_q;
    pend_d    = pend_q;
    disp_d    = disp_q;
    err_d     = err_q;

    if (key_valid && is_clr && (state_q != S_FLUSH)) begin
      a_d     = '0;
      b_d     = '0;
      cnt_a_d = '0;
      cnt_b_d = '0;
      op_d    = 2'b00;
      pend_d  = 1'b0;
      disp_d  = '0;
      err_d   = 1'b0;
      // An in-flight ALU operation must still be drained before new entry
      state_d = (state_q == S_EXEC && !alu_done) ? S_FLUSH : S_ENTER_A;
    end else begin
      unique case (state_q)
        S_ENTER_A: if (key_valid) begin
          if (is_digit) begin
            if (cnt_a_q != CNT_W'(MAX_DIGITS)) begin
              a_d     = acc(a_q, key_code);
              cnt_a_d = cnt_a_q + CNT_W'(1);
              disp_d  = a_d;
            end
          end else if (is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_ENTER_B;
          end
        end
        S_ENTER_B: if (key_valid) begin
          if (is_digit) begin
            if (cnt_b_q != CNT_W'(MAX_DIGITS)) begin
              b_d     = acc(b_q, key_code);
              cnt_b_d = cnt_b_q + CNT_W'(1);
              disp_d  = b_d;
            end
          end else if (is_op) begin
            if (cnt_b_q == '0) begin
              op_d = key_op;
            end else begin
              pend_op_d = key_op;
              pend_d    = 1'b1;
              state_d   = S_EXEC;
            end
          end else if (is_eq && (cnt_b_q != '0)) begin
            pend_d  = 1'b0;
            state_d = S_EXEC;
          end
        end
        S_EXEC: if (alu_done) begin
          if (alu_err) begin
            err_d   = 1'b1;
            disp_d  = '0;
            state_d = S_ERROR;
          end else begin
            a_d    = alu_result;
            disp_d = alu_result;
            if (pend_q) begin
              op_d    = pend_op_q;
              b_d     = '0;
              cnt_b_d = '0;
              state_d = S_ENTER_B;
            end else begin
              state_d = S_RESULT;
            end
          end
        end
        S_RESULT: if (key_valid) begin
          if (is_digit) begin
            a_d     = WIDTH'(key_code);
            cnt_a_d = CNT_W'(1);
            disp_d  = WIDTH'(key_code);
            state_d = S_ENTER_A;
          end else if (is_op) begin
            op_d    = key_op;
            b_d     = '0;
            cnt_b_d = '0;
            state_d = S_ENTER_B;
          end
        end
        S_FLUSH: if (alu_done) state_d = S_ENTER_A;
        default: ;
      endcase
    end

    start_d = (state_d == S_EXEC) && (state_q != S_EXEC);
    busy_d  = (state_d == S_EXEC) || (state_d == S_FLUSH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_ENTER_A;
      a_q       <= '0;
      b_q       <= '0;
      cnt_a_q   <= '0;
      cnt_b_q   <= '0;
      op_q      <= 2'b00;
      pend_op_q <= 2'b00;
      pend_q    <= 1'b0;
      disp_q    <= '0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_a_q   <= cnt_a_d;
      cnt_b_q   <= cnt_b_d;
      op_q      <= op_d;
      pend_op_q <= pend_op_d;
      pend_q    <= pend_d;
      disp_q    <= disp_d;
      err_q     <= err_d;
      start_q   <= start_d;
      busy_q    <= busy_d;
    end
  end

  assign alu_start = start_q;
  assign alu_op    = op_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign disp_val  = disp_q;
  assign disp_err  = err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Scoreboard bench for calc_seq_ctrl: a calculator-level model predicts display,
// busy and ALU launches; a monitor compares them against the DUT every cycle.
module tb_calc_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        alu_start;
  logic [1:0]  alu_op;
  logic [15:0] alu_a, alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        alu_err;
  logic [15:0] disp_val;
  logic        disp_err;
  logic        busy;

  calc_seq_ctrl #(.WIDTH(16), .MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
    .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_done(alu_done), .alu_result(alu_result), .alu_err(alu_err),
    .disp_val(disp_val), .disp_err(disp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int disp; bit err; bit busy; bit start; } cyc_exp_t;
  typedef struct { int a; int b; int op; } launch_t;
  typedef enum { M_A, M_B, M_EXEC, M_RES, M_ERR, M_FLUSH } mode_e;

  cyc_exp_t cyc_q[$];
  launch_t  launch_q[$];
  cyc_exp_t ce;
  launch_t  le;

  int n_checks = 0;
  int n_pass   = 0;

  // Calculator-level reference state
  mode_e m_mode;
  int    m_a, m_b, m_na, m_nb, m_op, m_pop, m_disp;
  bit    m_pend, m_err, m_start;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_mode = M_A; m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_pop = 0;
    m_disp = 0; m_pend = 0; m_err = 0; m_start = 0;
  endtask

  task automatic model_clear();
    m_a = 0; m_b = 0; m_na = 0; m_nb = 0; m_op = 0; m_disp = 0; m_err = 0; m_pend = 0;
  endtask

  task automatic launch();
    m_mode  = M_EXEC;
    m_start = 1;
    launch_q.push_back('{m_a, m_b, m_op});
  endtask

  task automatic model_alu(input int a, input int b, input int op, output int r, output bit e);
    e = 0;
    case (op)
      0: begin r = a + b; e = (r > 65535); end
      1: begin e = (a < b); r = a - b; end
      2: begin r = a * b; e = (r > 65535); end
      default: begin e = (b == 0); r = e ? 0 : a / b; end
    endcase
    if (e) r = int'($urandom_range(0, 65535));
    r = r & 65535;
  endtask

  task automatic model_step(input bit kv, input int kc, input bit dn, input int res, input bit er);
    m_start = 0;
    case (m_mode)
      M_EXEC: begin
        if (kv && kc == 15) begin
          model_clear();
          m_mode = dn ? M_A : M_FLUSH;
        end else if (dn) begin
          if (er) begin
            m_mode = M_ERR; m_err = 1; m_disp = 0;
          end else begin
            m_a = res; m_disp = res;
            if (m_pend) begin
              m_op = m_pop; m_b = 0; m_nb = 0; m_mode = M_B;
            end else m_mode = M_RES;
          end
        end
      end
      M_FLUSH: if (dn) m_mode = M_A;
      M_ERR:   if (kv && kc == 15) begin model_clear(); m_mode = M_A; end
      default: if (kv) begin
        if (kc == 15) begin
          model_clear(); m_mode = M_A;
        end else if (kc < 10) begin
          if (m_mode == M_A && m_na < 4) begin
            m_a = m_a * 10 + kc; m_na++; m_disp = m_a;
          end else if (m_mode == M_B && m_nb < 4) begin
            m_b = m_b * 10 + kc; m_nb++; m_disp = m_b;
          end else if (m_mode == M_RES) begin
            m_a = kc; m_na = 1; m_disp = kc; m_mode = M_A;
          end
        end else if (kc < 14) begin
          if (m_mode == M_B) begin
            if (m_nb == 0) m_op = kc - 10;
            else begin m_pop = kc - 10; m_pend = 1; launch(); end
          end else begin
            m_op = kc - 10; m_b = 0; m_nb = 0; m_mode = M_B;
          end
        end else if (m_mode == M_B && m_nb > 0) begin
          m_pend = 0; launch();
        end
      end
    endcase
  endtask

  task automatic cyc(input bit kv, input int kc, input bit dn, input int res, input bit er);
    @(negedge clk);
    key_valid = kv; key_code = 4'(kc); alu_done = dn; alu_result = 16'(res); alu_err = er;
    @(posedge clk);
    #1;
    key_valid = 0; alu_done = 0; alu_err = 0;
    model_step(kv, kc, dn, res, er);
    cyc_q.push_back('{m_disp, m_err, (m_mode == M_EXEC || m_mode == M_FLUSH), m_start});
  endtask

  task automatic key(input int kc);
    cyc(1, kc, 0, 0, 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  // ALU completion using the bench's own arithmetic, optionally with a coincident key
  task automatic alu_resp(input bit kv, input int kc);
    int r; bit e;
    model_alu(m_a, m_b, m_op, r, e);
    cyc(kv, kc, 1, r, e);
  endtask

  // Monitor: per-cycle outputs and ALU launch payloads
  always @(negedge clk) begin
    if (cyc_q.size() > 0) begin
      ce = cyc_q.pop_front();
      chk("disp_val", int'(disp_val), ce.disp);
      chk("disp_err", int'(disp_err), int'(ce.err));
      chk("busy", int'(busy), int'(ce.busy));
      chk("alu_start", int'(alu_start), int'(ce.start));
    end
    if (alu_start) begin
      if (launch_q.size() == 0) chk("unexpected_start", 1, 0);
      else begin
        le = launch_q.pop_front();
        chk("alu_a", int'(alu_a), le.a);
        chk("alu_b", int'(alu_b), le.b);
        chk("alu_op", int'(alu_op), le.op);
      end
    end
  end

  initial begin
    int r;
    rst = 0; key_valid = 0; key_code = 0; alu_done = 0; alu_result = 0; alu_err = 0;
    model_reset();
    #23;
    chk("rst_disp", int'(disp_val), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_start", int'(alu_start), 0);
    chk("rst_op", int'(alu_op), 0);
    chk("rst_err", int'(disp_err), 0);
    @(negedge clk);
    rst = 1;
    idle(1);

    // 12 + 3 = 15
    key(1); key(2); key(10); key(3); key(14); idle(2); alu_resp(0, 0);
    chk("t1_disp", int'(disp_val), 15);
    key(15);
    // Fifth digit ignored
    key(9); key(9); key(9); key(9); key(9);
    chk("t2_disp", int'(disp_val), 9999);
    key(15);
    // Operator replacement before any B digit
    key(5); key(12); key(11); key(2); key(14);
    chk("t3_op", int'(alu_op), 1);
    idle(1); alu_resp(0, 0); key(15);
    // Chained operators
    key(6); key(10); key(4); key(12); idle(1); alu_resp(0, 0);
    key(3); key(14); alu_resp(0, 0);
    chk("t4_disp", int'(disp_val), 30);
    // Divide by zero and error lockout
    key(15); key(8); key(13); key(0); key(14); idle(1); alu_resp(0, 0);
    chk("t5_err", int'(disp_err), 1);
    key(7); key(10); key(15);
    chk("t5_clr", int'(disp_err), 0);
    // Clear during EXEC, done arrives later and is discarded
    key(2); key(10); key(3); key(14); key(15); idle(2); alu_resp(0, 0);
    chk("t6_a", int'(alu_a), 0);
    chk("t6_busy", int'(busy), 0);
    // Clear coincident with done, and other key coincident with done
    key(4); key(10); key(4); key(14); alu_resp(1, 15);
    key(4); key(10); key(4); key(14); alu_resp(1, 7);
    key(15);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (m_mode == M_EXEC || m_mode == M_FLUSH) begin
        r = int'($urandom_range(0, 9));
        if (r < 4) idle(1);
        else if (r < 6) key(int'($urandom_range(0, 14)));
        else if (r == 6 && m_mode == M_EXEC) key(15);
        else if (r == 7) alu_resp(1, int'($urandom_range(0, 15)));
        else alu_resp(0, 0);
      end else begin
        r = int'($urandom_range(0, 99));
        if (m_mode == M_ERR && r < 40) key(15);
        else if (r < 55) key(int'($urandom_range(0, 9)));
        else if (r < 75) key(int'($urandom_range(10, 13)));
        else if (r < 88) key(14);
        else if (r < 92) key(15);
        else idle(1);
      end
    end
    if (m_mode == M_EXEC || m_mode == M_FLUSH) alu_resp(0, 0);
    key(15);

    // Reset while in EXEC; a later done must be ignored
    key(3); key(10); key(4); key(14); idle(1);
    @(posedge clk);
    #2 rst = 0;
    model_reset();
    #10;
    chk("rstx_busy", int'(busy), 0);
    @(posedge clk);
    #2 rst = 1;
    cyc(0, 0, 1, 7, 0);
    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("launch_q_empty", launch_q.size(), 0);
    chk("cyc_q_empty", cyc_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
